// File: rtl/adder_bk_pipe_pkg.sv
// Shared sizing helpers for the pipelined Brent-Kung adder.
// Levels, slice count and latency all derive from WIDTH and levels-per-stage.
package adder_bk_pkg;

  function automatic int bk_levels(input int width);
    return 2 * $clog2(width) - 1;
  endfunction

  function automatic int bk_slices(input int width, input int lps);
    return (bk_levels(width) + lps - 1) / lps;
  endfunction

  function automatic int bk_latency(input int width, input int lps);
    return bk_slices(width, lps) + 1;
  endfunction

  function automatic bit bk_params_ok(input int width, input int lps, input int tag_w);
    return (width >= 8) && (width <= 128) && ((width & (width - 1)) == 0) &&
           (lps >= 1) && (lps <= bk_levels(width)) && (tag_w >= 1);
  endfunction

endpackage

// File: rtl/adder_bk_pipe_if.sv
// Operand/result handshake bundle for adder_bk_pipe.
interface adder_bk_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             sub_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output in_valid_i, a_i, b_i, cin_i, sub_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, tag_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, cin_i, sub_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, tag_o
  );
endinterface

// File: rtl/adder_bk_pipe_prefix_level.sv
// One combinational Brent-Kung prefix level: up-sweep levels use black cells,
// down-sweep levels use gray cells; untouched positions pass straight through.
module black_cell (
  input  logic p_hi,
  input  logic g_hi,
  input  logic p_lo,
  input  logic g_lo,
  output logic p,
  output logic g
);
  assign p = p_hi & p_lo;
  assign g = g_hi | (p_hi & g_lo);
endmodule

module gray_cell (
  input  logic p_hi,
  input  logic g_hi,
  input  logic g_lo,
  output logic g
);
  assign g = g_hi | (p_hi & g_lo);
endmodule

module bk_prefix_level #(
  parameter int WIDTH = 32,
  parameter int LEVEL = 0
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] g_out
);
  localparam int LOG_W = $clog2(WIDTH);
  localparam bit UP    = (LEVEL < LOG_W);
  // Down-sweep distance shrinks from WIDTH/4 back to 1.
  localparam int DIST  = UP ? (1 << LEVEL) : (1 << (2 * LOG_W - 2 - LEVEL));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (UP && (((i + 1) % (2 * DIST)) == 0)) begin : g_black
      black_cell u_cell (
        .p_hi (p_in[i]),
        .g_hi (g_in[i]),
        .p_lo (p_in[i-DIST]),
        .g_lo (g_in[i-DIST]),
        .p    (p_out[i]),
        .g    (g_out[i])
      );
    end else if (!UP && (((i + 1) % (2 * DIST)) == DIST) && ((i + 1) > 2 * DIST)) begin : g_gray
      gray_cell u_cell (
        .p_hi (p_in[i]),
        .g_hi (g_in[i]),
        .g_lo (g_in[i-DIST]),
        .g    (g_out[i])
      );
      assign p_out[i] = p_in[i];
    end else begin : g_pass
      assign p_out[i] = p_in[i];
      assign g_out[i] = g_in[i];
    end
  end
endmodule

// File: rtl/adder_bk_pipe.sv
// Pipelined Brent-Kung add/subtract with valid/ready; a register slice closes
// every LEVELS_PER_STAGE prefix levels and one output register follows.
module adder_bk_pipe
  import adder_bk_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 3,
  parameter int TAG_W            = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  adder_bk_pipe_if.slave bus
);
  localparam int LPS = LEVELS_PER_STAGE;
  localparam int D   = bk_levels(WIDTH);
  localparam int N   = bk_slices(WIDTH, LPS);

  if (!bk_params_ok(WIDTH, LPS, TAG_W)) begin : g_param_err
    $error("adder_bk_pipe: illegal WIDTH/LEVELS_PER_STAGE/TAG_W");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff, p0, g0;
  logic             cin0;

  logic [WIDTH-1:0] lv_pi [D];
  logic [WIDTH-1:0] lv_gi [D];
  logic [WIDTH-1:0] lv_po [D];
  logic [WIDTH-1:0] lv_go [D];

  logic [WIDTH-1:0] st_p   [N];
  logic [WIDTH-1:0] st_g   [N];
  logic [WIDTH-1:0] st_po  [N];
  logic             st_cin [N];
  logic [TAG_W-1:0] st_tag [N];
  logic             st_v   [N];

  logic             out_valid_q, cout_q, ovf_q;
  logic [WIDTH-1:0] sum_q, g_last;
  logic [TAG_W-1:0] tag_q;

  assign adv            = !out_valid_q || bus.out_ready_i;
  assign bus.in_ready_o = adv;

  // Carry-in folds into bit 0's generate, so the tree output is the full carry.
  always_comb begin
    b_eff = bus.sub_i ? ~bus.b_i : bus.b_i;
    cin0  = bus.sub_i | bus.cin_i;
    p0    = bus.a_i ^ b_eff;
    g0    = bus.a_i & b_eff;
    g0[0] = g0[0] | (p0[0] & cin0);
  end

  for (genvar k = 0; k < D; k++) begin : g_level
    if (k == 0) begin : g_src_in
      assign lv_pi[k] = p0;
      assign lv_gi[k] = g0;
    end else if ((k % LPS) == 0) begin : g_src_reg
      assign lv_pi[k] = st_p[k/LPS-1];
      assign lv_gi[k] = st_g[k/LPS-1];
    end else begin : g_src_comb
      assign lv_pi[k] = lv_po[k-1];
      assign lv_gi[k] = lv_go[k-1];
    end

    bk_prefix_level #(.WIDTH(WIDTH), .LEVEL(k)) u_level (
      .p_in  (lv_pi[k]),
      .g_in  (lv_gi[k]),
      .p_out (lv_po[k]),
      .g_out (lv_go[k])
    );
  end

  for (genvar s = 0; s < N; s++) begin : g_slice
    localparam int LAST = ((s + 1) * LPS < D) ? (s + 1) * LPS - 1 : D - 1;

    logic [WIDTH-1:0] po_d, p_q, g_q, po_q;
    logic             cin_d, v_d, cin_q, v_q;
    logic [TAG_W-1:0] tag_d, tag_q;

    if (s == 0) begin : g_head
      assign po_d  = p0;
      assign cin_d = cin0;
      assign tag_d = bus.tag_i;
      assign v_d   = bus.in_valid_i;
    end else begin : g_body
      assign po_d  = st_po[s-1];
      assign cin_d = st_cin[s-1];
      assign tag_d = st_tag[s-1];
      assign v_d   = st_v[s-1];
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        p_q   <= '0;
        g_q   <= '0;
        po_q  <= '0;
        cin_q <= 1'b0;
        tag_q <= '0;
        v_q   <= 1'b0;
      end else if (adv) begin
        p_q   <= lv_po[LAST];
        g_q   <= lv_go[LAST];
        po_q  <= po_d;
        cin_q <= cin_d;
        tag_q <= tag_d;
        v_q   <= v_d;
      end
    end

    assign st_p[s]   = p_q;
    assign st_g[s]   = g_q;
    assign st_po[s]  = po_q;
    assign st_cin[s] = cin_q;
    assign st_tag[s] = tag_q;
    assign st_v[s]   = v_q;
  end

  // g_last[i] is the carry out of bit i.
  assign g_last = st_g[N-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tag_q       <= '0;
    end else if (adv) begin
      out_valid_q <= st_v[N-1];
      sum_q       <= st_po[N-1] ^ {g_last[WIDTH-2:0], st_cin[N-1]};
      cout_q      <= g_last[WIDTH-1];
      ovf_q       <= g_last[WIDTH-1] ^ g_last[WIDTH-2];
      tag_q       <= st_tag[N-1];
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.sum_o       = sum_q;
  assign bus.cout_o      = cout_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.tag_o       = tag_q;
endmodule

// File: tb/tb_adder_bk_pipe.sv
// Scoreboard bench for adder_bk_pipe at WIDTH=32/LPS=3 and WIDTH=8/LPS=5,
// with an arithmetic reference model and decoupled output monitors.
module tb_adder_bk_pipe;
  localparam int LAT32 = 4;
  localparam int LAT8  = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   pops32 = 0;
  int   last_pop32 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_bk_pipe_if #(.WIDTH(32), .TAG_W(4)) bus32 ();
  adder_bk_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();

  adder_bk_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(3), .TAG_W(4)) u_dut32 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus32)
  );

  adder_bk_pipe #(.WIDTH(8), .LEVELS_PER_STAGE(5), .TAG_W(4)) u_dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus8)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Plain integer arithmetic: unsigned result for sum/cout, signed result for overflow.
  function automatic exp_t ref_op(input int w, input longint a, input longint b,
                                  input bit cin, input bit sub, input logic [3:0] tag);
    exp_t   r;
    longint full, sa, sb, u, s;
    full = longint'(1) << w;
    sa   = (a >= full / 2) ? a - full : a;
    sb   = (b >= full / 2) ? b - full : b;
    if (sub) begin
      u      = a - b;
      s      = sa - sb;
      r.cout = (a >= b);
    end else begin
      u      = a + b + longint'(cin);
      s      = sa + sb + longint'(cin);
      r.cout = (u >= full);
    end
    r.sum     = 32'(u & (full - 1));
    r.ovf     = (s >= full / 2) || (s < -(full / 2));
    r.tag     = tag;
    r.acc     = 0;
    r.chk_lat = 1'b0;
    return r;
  endfunction

  always @(negedge clk) begin : mon32
    exp_t e;
    if (bus32.out_valid_o === 1'b1 && bus32.out_ready_i === 1'b1) begin
      if (sb32.size() == 0) begin
        chk("w32_spurious_result", 64'(bus32.out_valid_o), 64'(0));
      end else begin
        e = sb32.pop_front();
        pops32++;
        last_pop32 = cyc;
        chk("w32_sum",  64'(bus32.sum_o),  64'(e.sum));
        chk("w32_cout", 64'(bus32.cout_o), 64'(e.cout));
        chk("w32_ovf",  64'(bus32.ovf_o),  64'(e.ovf));
        chk("w32_tag",  64'(bus32.tag_o),  64'(e.tag));
        if (e.chk_lat) chk("w32_latency", 64'(cyc - e.acc), 64'(LAT32));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (bus8.out_valid_o === 1'b1 && bus8.out_ready_i === 1'b1) begin
      if (sb8.size() == 0) begin
        chk("w8_spurious_result", 64'(bus8.out_valid_o), 64'(0));
      end else begin
        e = sb8.pop_front();
        chk("w8_sum",  64'(bus8.sum_o),  64'(e.sum));
        chk("w8_cout", 64'(bus8.cout_o), 64'(e.cout));
        chk("w8_ovf",  64'(bus8.ovf_o),  64'(e.ovf));
        chk("w8_tag",  64'(bus8.tag_o),  64'(e.tag));
        if (e.chk_lat) chk("w8_latency", 64'(cyc - e.acc), 64'(LAT8));
      end
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input logic [3:0] tag, input bit lat);
    exp_t e;
    int   n;
    bus32.a_i = a; bus32.b_i = b; bus32.cin_i = cin; bus32.sub_i = sub; bus32.tag_i = tag;
    bus32.in_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus32.in_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus32.in_ready_o !== 1'b1) begin
      chk("w32_accept_timeout", 64'(bus32.in_ready_o), 64'(1));
    end else begin
      e = ref_op(32, longint'(a), longint'(b), cin, sub, tag);
      e.acc = cyc;
      e.chk_lat = lat;
      sb32.push_back(e);
    end
    @(posedge clk);
    #1;
    bus32.in_valid_i = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [3:0] tag, input bit lat);
    exp_t e;
    int   n;
    bus8.a_i = a; bus8.b_i = b; bus8.cin_i = cin; bus8.sub_i = sub; bus8.tag_i = tag;
    bus8.in_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus8.in_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus8.in_ready_o !== 1'b1) begin
      chk("w8_accept_timeout", 64'(bus8.in_ready_o), 64'(1));
    end else begin
      e = ref_op(8, longint'(a), longint'(b), cin, sub, tag);
      e.acc = cyc;
      e.chk_lat = lat;
      sb8.push_back(e);
    end
    @(posedge clk);
    #1;
    bus8.in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb32.size() != 0 || sb8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb32.size() + sb8.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int start;

    rst = 1'b1;
    bus32.in_valid_i = 1'b0; bus32.out_ready_i = 1'b1;
    bus32.a_i = '0; bus32.b_i = '0; bus32.cin_i = 1'b0; bus32.sub_i = 1'b0; bus32.tag_i = '0;
    bus8.in_valid_i = 1'b0; bus8.out_ready_i = 1'b1;
    bus8.a_i = '0; bus8.b_i = '0; bus8.cin_i = 1'b0; bus8.sub_i = 1'b0; bus8.tag_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 64'(bus32.out_valid_o), 64'(0));
    chk("rst_sum",       64'(bus32.sum_o),       64'(0));
    chk("rst_cout",      64'(bus32.cout_o),      64'(0));
    chk("rst_ovf",       64'(bus32.ovf_o),       64'(0));
    chk("rst_tag",       64'(bus32.tag_o),       64'(0));
    chk("rst_in_ready",  64'(bus32.in_ready_o),  64'(1));
    chk("rst8_out_valid", 64'(bus8.out_valid_o), 64'(0));
    chk("rst8_in_ready",  64'(bus8.in_ready_o),  64'(1));
    @(posedge clk);
    #1;

    // Directed corner cases, one at a time so latency is exact.
    issue32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h1, 1'b1);
    wait_drain();
    issue32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'h2, 1'b1);
    wait_drain();
    issue32(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 4'h3, 1'b1);
    wait_drain();
    issue32(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 4'h4, 1'b1);
    wait_drain();

    // Back-to-back random traffic at full rate.
    base  = pops32;
    start = cyc;
    for (int i = 0; i < 64; i++)
      issue32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i), 1'b0);
    chk("b2b_issue_cycles", 64'(cyc - start), 64'(64));
    wait_drain();
    chk("b2b_result_count", 64'(pops32 - base), 64'(64));
    chk("b2b_last_result_cycle", 64'(last_pop32 - start), 64'(63 + LAT32));

    // Backpressure: full pipe, consumer stalls for three cycles.
    base = pops32;
    fork
      begin
        for (int i = 0; i < 12; i++)
          issue32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i), 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        bus32.out_ready_i = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_out_valid", 64'(bus32.out_valid_o), 64'(1));
          chk("stall_in_ready",  64'(bus32.in_ready_o),  64'(0));
          chk("stall_sum_held",  64'(bus32.sum_o),       64'(sb32[0].sum));
          chk("stall_tag_held",  64'(bus32.tag_o),       64'(sb32[0].tag));
        end
        @(posedge clk);
        #1;
        bus32.out_ready_i = 1'b1;
      end
    join
    wait_drain();
    chk("stall_result_count", 64'(pops32 - base), 64'(12));

    // Reset with three operations in flight: all of them must vanish.
    issue32(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 4'hA, 1'b0);
    issue32(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0, 4'hB, 1'b0);
    issue32(32'h5555_5555, 32'h0000_0001, 1'b0, 1'b1, 4'hC, 1'b0);
    rst = 1'b1;
    sb32.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(bus32.out_valid_o), 64'(0));
    chk("midrst_in_ready",  64'(bus32.in_ready_o),  64'(1));
    chk("midrst_sum",       64'(bus32.sum_o),       64'(0));
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    issue32(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 4'hD, 1'b1);
    wait_drain();

    // 8-bit single-slice configuration.
    issue8(8'h7F, 8'h01, 1'b0, 1'b0, 4'h5, 1'b1);
    wait_drain();
    issue8(8'h00, 8'h00, 1'b1, 1'b0, 4'h6, 1'b1);
    wait_drain();
    issue8(8'h80, 8'h01, 1'b0, 1'b1, 4'h7, 1'b1);
    wait_drain();
    for (int i = 0; i < 24; i++)
      issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i), 1'b0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_bk_pipe.md
# adder_bk_pipe

Parametrised, pipelined Brent-Kung prefix adder/subtractor with valid/ready flow control. It generalises the fixed 8-bit combinational Brent-Kung carry tree to any power-of-two width. Register slices are inserted at a configurable prefix-level interval, and a per-operation mode (add/sub), carry-in, carry-out, signed-overflow and a pass-through tag are added. It sits in the datapath primitives layer and feeds ALU/accumulator blocks that need a high-fmax wide adder.

## Interface
- WIDTH, 32: operand width; power of two, 8..128.
- LEVELS_PER_STAGE, 3: prefix levels evaluated between pipeline registers; range 1..(2·log2(WIDTH)−1).
- TAG_W, 4: width of the sideband tag carried alongside each operation; ≥1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- in_valid_i  in  1  operation present on inputs.
- in_ready_o  out  1  block accepts operation this cycle.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- cin_i  in  1  carry-in; ignored when sub_i=1.
- sub_i  in  1  0: A+B+cin; 1: A−B (A+~B+1).
- tag_i  in  TAG_W  sideband, returned unchanged with the result.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- sum_o  out  WIDTH  result.
- cout_o  out  1  carry out of MSB; for subtract, 1 means no borrow.
- ovf_o  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- tag_o  out  TAG_W  tag of the result.

## Operation
- Prefix depth D = 2·log2(WIDTH)−1 levels: up-sweep of black cells, then down-sweep of gray cells. The topology matches the 8-bit carry tree and generalises it.
- The carry-in is folded in as generate bit position −1, so gen_to_0 includes cin.
- Slice count N = ceil(D / LEVELS_PER_STAGE).
- Slice 0 also performs B inversion for subtract and p/g generation (p = a^b', g = a&b').
- Each slice ends in a register holding:
  - current group p/g vectors
  - original p vector
  - cin
  - tag
  - stage valid bit
- The final sum XOR, cout and ovf are computed from slice N−1 outputs and captured in the output register.
- Flow control uses a single global advance: adv = !out_valid_o || out_ready_i.
  - in_ready_o = adv (combinational).
  - All stage registers load only when adv=1.
  - A stage valid bit loads the previous stage's valid bit; stage 0 loads in_valid_i.
- Bubbles are not collapsed. An invalid stage still occupies a slot until adv.
- Operations complete in acceptance order. Tag travels with its operation.
- A transfer occurs when valid and ready are both high in the same cycle.
  - Outputs hold stable while out_valid_o=1 and out_ready_i=0.
  - in_ready_o=0 in that state.
- Widths:
  - sum_o wraps modulo 2^WIDTH.
  - No internal width growth beyond the p/g vectors, plus one bit for the cin position.

## Timing
- Latency LAT = N+1 cycles from the accepting edge to out_valid_o=1, with no stalls.
  - WIDTH=32, LPS=3: D=9, N=3, LAT=4.
  - WIDTH=8, LPS=5: LAT=2.
- Throughput is one operation per cycle when out_ready_i is held high.
- Reset:
  - On the edge where rst_i=1, all stage valid bits clear, and out_valid_o, sum_o, cout_o, ovf_o and tag_o clear to 0.
  - in_ready_o=1 in the cycle after reset.
- Reset mid-operation discards all in-flight operations. None is ever presented.
- Reset takes priority over adv when both are asserted.
- With in_valid_i=1 and in_ready_o=0, the operation is not taken. The source must hold it.
- Simultaneous output acceptance and input acceptance in a full pipe is legal and sustains full rate.

## Structure
- Package adder_bk_pkg holds:
  - function bk_levels(width), returning D
  - function bk_slices(width, lps), returning N
  - function bk_latency(width, lps), returning LAT
  - typedef-free parameter checks (elaboration $error on a non-power-of-two WIDTH or an out-of-range LPS)
- Sub-module bk_prefix_level is the combinational single prefix level for a given level index. It is built from the existing black_cell/gray_cell primitives. The top generates D instances and places registers after every LPS-th level.

## Test plan
- WIDTH=32, LPS=3: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 → sum 0x00000000, cout 1, ovf 0, out_valid_o exactly 4 cycles after acceptance.
- sub=1, a=0x80000000, b=0x00000001 → sum 0x7FFFFFFF, cout 1, ovf 1; sub=1, a=0, b=1 → sum 0xFFFFFFFF, cout 0, ovf 0.
- 64 back-to-back random ops with tags 0..15 and out_ready_i=1 → one result per cycle, bit-exact versus the reference model, tags in issue order.
- Fill the pipe, drop out_ready_i for 3 cycles → in_ready_o=0, outputs frozen. Then raise it → all results delivered, none lost or duplicated.
- Assert rst_i for 1 cycle with 3 ops in flight → out_valid_o=0 from the next cycle, no stale results emerge, and the next accepted op returns after LAT cycles.
- WIDTH=8, LPS=5: a=0x7F, b=0x01, cin=0 → sum 0x80, cout 0, ovf 1, latency 2. a=0x00, b=0x00, cin=1 → 0x01.
